// File: rtl/axi_mem_responder_pkg.sv
// Shared encodings, FSM states and burst legality helper for axi_mem_responder.
// Define AXI_MEM_RESPONDER_WRAP_EN to support WRAP bursts.
package axi_mem_responder_pkg;

`ifdef AXI_MEM_RESPONDER_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // Whole-burst error: oversized beats, reserved burst type, or an unsupported WRAP.
  function automatic logic burst_is_slverr(input logic [2:0] size, input logic [1:0] burst,
                                           input logic [7:0] len, input logic [2:0] max_size);
    logic wrap_ok;
    wrap_ok = WRAP_EN && (len inside {8'd1, 8'd3, 8'd7, 8'd15});
    return (size > max_size) || (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_ok);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next beat address for FIXED / INCR / WRAP bursts (WRAP only with AXI_MEM_RESPONDER_WRAP_EN).
module axi_burst_addr_gen
  import axi_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr_c
);

  logic [ADDR_W-1:0] incr_c;
  logic [ADDR_W-1:0] wrap_mask_c;

  always_comb begin
    incr_c      = addr + (ADDR_W'(1) << size);
    // Wrap window is (len+1) beats of 2^size bytes, aligned to its own size.
    wrap_mask_c = (ADDR_W'({1'b0, len} + 9'd1) << size) - ADDR_W'(1);
    unique case (burst)
      BURST_FIXED: next_addr_c = addr;
      BURST_WRAP:  next_addr_c = WRAP_EN ? ((addr & ~wrap_mask_c) | (incr_c & wrap_mask_c))
                                         : incr_c;
      default:     next_addr_c = incr_c;
    endcase
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate terminating bursts in an internal word array; independent read/write paths.
// Optional WRAP burst support with AXI_MEM_RESPONDER_WRAP_EN.
module axi_mem_responder
  import axi_mem_responder_pkg::*;
#(
  parameter int unsigned LOCAL_DATA_WIDTH = 32,
  parameter int unsigned LOCAL_ADDR_WIDTH = 32,
  parameter int unsigned LOCAL_ID_WIDTH   = 2,
  parameter int unsigned MEM_DEPTH        = 1024
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_areset,
  input  logic [LOCAL_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [LOCAL_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                    s_axi_awlen,
  input  logic [2:0]                    s_axi_awsize,
  input  logic [1:0]                    s_axi_awburst,
  input  logic                          s_axi_awlock,
  input  logic [3:0]                    s_axi_awcache,
  input  logic [2:0]                    s_axi_awprot,
  input  logic [3:0]                    s_axi_awqos,
  input  logic [3:0]                    s_axi_awregion,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [LOCAL_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [LOCAL_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                          s_axi_wlast,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [LOCAL_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [LOCAL_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [LOCAL_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                    s_axi_arlen,
  input  logic [2:0]                    s_axi_arsize,
  input  logic [1:0]                    s_axi_arburst,
  input  logic                          s_axi_arlock,
  input  logic [3:0]                    s_axi_arcache,
  input  logic [2:0]                    s_axi_arprot,
  input  logic [3:0]                    s_axi_arqos,
  input  logic [3:0]                    s_axi_arregion,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [LOCAL_ID_WIDTH-1:0]     s_axi_rid,
  output logic [LOCAL_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rlast,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready
);

  localparam int unsigned DW       = LOCAL_DATA_WIDTH;
  localparam int unsigned AW       = LOCAL_ADDR_WIDTH;
  localparam int unsigned IW       = LOCAL_ID_WIDTH;
  localparam int unsigned STRB_W   = DW / 8;
  localparam int unsigned BYTE_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
  localparam int unsigned LIM_W    = BYTE_LSB + IDX_W;

  logic [DW-1:0] mem_q [MEM_DEPTH];

  // Write path state
  w_state_e        w_state_q, w_state_d;
  logic [IW-1:0]   aw_id_q, aw_id_d;
  logic [AW-1:0]   aw_addr_q, aw_addr_d;
  logic [7:0]      aw_len_q, aw_len_d;
  logic [2:0]      aw_size_q, aw_size_d;
  logic [1:0]      aw_burst_q, aw_burst_d;
  logic [7:0]      w_cnt_q, w_cnt_d;
  logic            w_slv_q, w_slv_d;
  logic            w_oor_q, w_oor_d;
  logic            awready_q, awready_d;
  logic            wready_q, wready_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [IW-1:0]   bid_q, bid_d;
  logic [AW-1:0]   w_next_addr_c;
  logic [IDX_W-1:0] w_idx_c;
  logic            w_oor_c;
  logic            mem_we_c;

  // Read path state
  r_state_e        r_state_q, r_state_d;
  logic [IW-1:0]   ar_id_q, ar_id_d;
  logic [AW-1:0]   ar_addr_q, ar_addr_d;
  logic [7:0]      ar_len_q, ar_len_d;
  logic [2:0]      ar_size_q, ar_size_d;
  logic [1:0]      ar_burst_q, ar_burst_d;
  logic [7:0]      r_cnt_q, r_cnt_d;
  logic            r_slv_q, r_slv_d;
  logic            arready_q, arready_d;
  logic            rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic            rlast_q, rlast_d;
  logic [IW-1:0]   rid_q, rid_d;
  logic [AW-1:0]   r_next_addr_c;
  logic [IDX_W-1:0] r_idx_c;
  logic            r_oor_c;
  logic            r_load_c;
  logic [7:0]      r_cnt_nxt_c;

  logic unused_c;
  assign unused_c = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion,
                      s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion};

  assign w_idx_c = aw_addr_q[BYTE_LSB +: IDX_W];
  assign w_oor_c = (aw_addr_q >> LIM_W) != '0;
  assign r_idx_c = ar_addr_q[BYTE_LSB +: IDX_W];
  assign r_oor_c = (ar_addr_q >> LIM_W) != '0;
  assign r_cnt_nxt_c = r_cnt_q + 8'd1;

  axi_burst_addr_gen #(.ADDR_W(AW)) u_w_addr_gen (
    .addr        (aw_addr_q),
    .len         (aw_len_q),
    .size        (aw_size_q),
    .burst       (aw_burst_q),
    .next_addr_c (w_next_addr_c)
  );

  axi_burst_addr_gen #(.ADDR_W(AW)) u_r_addr_gen (
    .addr        (ar_addr_q),
    .len         (ar_len_q),
    .size        (ar_size_q),
    .burst       (ar_burst_q),
    .next_addr_c (r_next_addr_c)
  );

  // Write FSM next state
  always_comb begin
    w_state_d  = w_state_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    w_cnt_d    = w_cnt_q;
    w_slv_d    = w_slv_q;
    w_oor_d    = w_oor_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    bid_d      = bid_q;
    mem_we_c   = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (s_axi_awvalid && awready_q) begin
          aw_id_d    = s_axi_awid;
          aw_addr_d  = s_axi_awaddr;
          aw_len_d   = s_axi_awlen;
          aw_size_d  = s_axi_awsize;
          aw_burst_d = s_axi_awburst;
          w_slv_d    = burst_is_slverr(s_axi_awsize, s_axi_awburst, s_axi_awlen, 3'(BYTE_LSB));
          w_oor_d    = 1'b0;
          w_cnt_d    = 8'd0;
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          w_state_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid && wready_q) begin
          mem_we_c  = !w_slv_q && !w_oor_c && !s_axi_areset;
          aw_addr_d = w_next_addr_c;
          w_cnt_d   = w_cnt_q + 8'd1;
          w_oor_d   = w_oor_q || w_oor_c;
          if (s_axi_wlast || (w_cnt_q == aw_len_q)) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = aw_id_q;
            bresp_d   = w_slv_q ? RESP_SLVERR : ((w_oor_q || w_oor_c) ? RESP_DECERR : RESP_OKAY);
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && s_axi_bready) begin
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          bid_d     = '0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_state_q  <= W_IDLE;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_cnt_q    <= '0;
      w_slv_q    <= 1'b0;
      w_oor_q    <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      bid_q      <= '0;
    end else begin
      w_state_q  <= w_state_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      w_cnt_q    <= w_cnt_d;
      w_slv_q    <= w_slv_d;
      w_oor_q    <= w_oor_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      bid_q      <= bid_d;
    end
  end

  // Array is never reset; byte lanes follow wstrb.
  always_ff @(posedge s_axi_aclk) begin
    if (mem_we_c) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem_q[w_idx_c][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // Read FSM next state; a beat is loaded into the output register one cycle ahead.
  always_comb begin
    r_state_d  = r_state_q;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    r_cnt_d    = r_cnt_q;
    r_slv_d    = r_slv_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;
    rid_d      = rid_q;
    r_load_c   = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (s_axi_arvalid && arready_q) begin
          ar_id_d    = s_axi_arid;
          ar_addr_d  = s_axi_araddr;
          ar_len_d   = s_axi_arlen;
          ar_size_d  = s_axi_arsize;
          ar_burst_d = s_axi_arburst;
          r_slv_d    = burst_is_slverr(s_axi_arsize, s_axi_arburst, s_axi_arlen, 3'(BYTE_LSB));
          r_cnt_d    = 8'd0;
          arready_d  = 1'b0;
          r_state_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (!rvalid_q) begin
          r_load_c = 1'b1;
          rlast_d  = (ar_len_q == 8'd0);
        end else if (s_axi_rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            rdata_d   = '0;
            rresp_d   = RESP_OKAY;
            rid_d     = '0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            r_load_c = 1'b1;
            r_cnt_d  = r_cnt_nxt_c;
            rlast_d  = (r_cnt_nxt_c == ar_len_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (r_load_c) begin
      rvalid_d  = 1'b1;
      rid_d     = ar_id_q;
      rdata_d   = (r_slv_q || r_oor_c) ? '0 : mem_q[r_idx_c];
      rresp_d   = r_slv_q ? RESP_SLVERR : (r_oor_c ? RESP_DECERR : RESP_OKAY);
      ar_addr_d = r_next_addr_c;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state_q  <= R_IDLE;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_cnt_q    <= '0;
      r_slv_q    <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
    end else begin
      r_state_q  <= r_state_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      r_cnt_q    <= r_cnt_d;
      r_slv_q    <= r_slv_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
      rid_q      <= rid_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rid     = rid_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder (default parameters).
module tb_axi_mem_responder;

  logic        clk = 1'b0;
  logic        areset;
  logic [1:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;

  int checks = 0;
  int errors = 0;

  logic [31:0] wbeat   [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [1:0]  rd_id;
  int          rd_n;
  logic [1:0]  b_resp, b_id;

  always #5 clk = ~clk;

  axi_mem_responder dut (
    .s_axi_aclk(clk), .s_axi_areset(areset),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'h0), .s_axi_awprot(3'h0),
    .s_axi_awqos(4'h0), .s_axi_awregion(4'h0), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(1'b1), .s_axi_arcache(4'hF), .s_axi_arprot(3'h7),
    .s_axi_arqos(4'hF), .s_axi_arregion(4'hF), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                       input logic [1:0] bt, input logic [1:0] id);
    int n = 0;
    awaddr = a; awlen = l; awsize = s; awburst = bt; awid = id; awvalid = 1'b1;
    while (awready !== 1'b1 && n < 50) begin step(); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL aw_timeout addr %h", a); end
    step();
    awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [7:0] l, input logic [3:0] strb);
    for (int i = 0; i <= int'(l); i++) begin
      int n = 0;
      wdata = wbeat[i]; wstrb = strb; wlast = (i == int'(l)); wvalid = 1'b1;
      while (wready !== 1'b1 && n < 50) begin step(); n++; end
      if (n >= 50) begin checks++; errors++; $display("FAIL w_timeout beat %0d", i); end
      step();
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic do_b();
    int n = 0;
    bready = 1'b1;
    while (bvalid !== 1'b1 && n < 50) begin step(); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL b_timeout"); end
    b_resp = bresp; b_id = bid;
    step();
    bready = 1'b0;
  endtask

  task automatic write_burst(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                             input logic [1:0] bt, input logic [1:0] id, input logic [3:0] strb);
    do_aw(a, l, s, bt, id);
    do_w(l, strb);
    do_b();
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                       input logic [1:0] bt, input logic [1:0] id);
    int n = 0;
    araddr = a; arlen = l; arsize = s; arburst = bt; arid = id; arvalid = 1'b1;
    while (arready !== 1'b1 && n < 50) begin step(); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL ar_timeout addr %h", a); end
    step();
    arvalid = 1'b0;
  endtask

  task automatic do_r(input logic [7:0] l);
    int n = 0;
    rready = 1'b1; rd_n = 0;
    while (rd_n <= int'(l) && n < 300) begin
      if (rvalid === 1'b1) begin
        rd_data[rd_n] = rdata; rd_resp[rd_n] = rresp; rd_last[rd_n] = rlast; rd_id = rid;
        rd_n++;
      end
      step(); n++;
    end
    rready = 1'b0;
    if (rd_n <= int'(l)) begin checks++; errors++; $display("FAIL r_timeout got %0d beats", rd_n); end
  endtask

  task automatic read_burst(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                            input logic [1:0] bt, input logic [1:0] id);
    do_ar(a, l, s, bt, id);
    do_r(l);
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) step();
    checks++; if (awready !== 1'b0) begin errors++; $display("FAIL rst_awready got %b exp 0", awready); end
    checks++; if (arready !== 1'b0) begin errors++; $display("FAIL rst_arready got %b exp 0", arready); end
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL rst_wready got %b exp 0", wready); end
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid got %b exp 0", bvalid); end
    checks++; if (rvalid !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL rst_r got %b/%h exp 0/0", rvalid, rdata); end
    areset = 1'b0;
    step();
    checks++; if (awready !== 1'b1) begin errors++; $display("FAIL rst_rel_awready got %b exp 1", awready); end
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL rst_rel_arready got %b exp 1", arready); end
  endtask

  task automatic test_incr();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'hA0; exp_d[1] = 32'hA1; exp_d[2] = 32'hA2; exp_d[3] = 32'hA3;
    for (int i = 0; i < 4; i++) wbeat[i] = exp_d[i];
    write_burst(32'h10, 8'd3, 3'd2, 2'b01, 2'd2, 4'hF);
    checks++; if (b_resp !== 2'b00) begin errors++; $display("FAIL incr_bresp got %b exp 00", b_resp); end
    checks++; if (b_id !== 2'd2) begin errors++; $display("FAIL incr_bid got %0d exp 2", b_id); end
    do_ar(32'h10, 8'd3, 3'd2, 2'b01, 2'd1);
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL incr_rvalid_early got %b exp 0", rvalid); end
    step();
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL incr_rvalid_lat got %b exp 1", rvalid); end
    do_r(8'd3);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== exp_d[i] || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3)) begin
        errors++;
        $display("FAIL incr_beat%0d got %h/%b/%b exp %h/00/%b", i, rd_data[i], rd_resp[i], rd_last[i], exp_d[i], i == 3);
      end
    end
    checks++; if (rd_id !== 2'd1) begin errors++; $display("FAIL incr_rid got %0d exp 1", rd_id); end
  endtask

  task automatic test_strb();
    wbeat[0] = 32'hFFFF_FFFF;
    write_burst(32'h0, 8'd0, 3'd2, 2'b01, 2'd0, 4'hF);
    wbeat[0] = 32'h0000_00AB;
    write_burst(32'h0, 8'd0, 3'd2, 2'b01, 2'd0, 4'h1);
    read_burst(32'h0, 8'd0, 3'd2, 2'b01, 2'd0);
    checks++; if (rd_data[0] !== 32'hFFFF_FFAB) begin errors++; $display("FAIL strb_merge got %h exp ffffffab", rd_data[0]); end
  endtask

  task automatic test_oor();
    logic [31:0] exp_d [4];
    logic [1:0]  exp_r [4];
    wbeat[0] = 32'hD000_0000; wbeat[1] = 32'hD000_0001;
    write_burst(32'hFF8, 8'd1, 3'd2, 2'b01, 2'd0, 4'hF);
    checks++; if (b_resp !== 2'b00) begin errors++; $display("FAIL oor_prefill_bresp got %b exp 00", b_resp); end
    exp_d[0] = 32'hD000_0000; exp_d[1] = 32'hD000_0001; exp_d[2] = 32'h0; exp_d[3] = 32'h0;
    exp_r[0] = 2'b00; exp_r[1] = 2'b00; exp_r[2] = 2'b11; exp_r[3] = 2'b11;
    read_burst(32'hFF8, 8'd3, 3'd2, 2'b01, 2'd3);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== exp_d[i] || rd_resp[i] !== exp_r[i]) begin
        errors++;
        $display("FAIL oor_rbeat%0d got %h/%b exp %h/%b", i, rd_data[i], rd_resp[i], exp_d[i], exp_r[i]);
      end
    end
    for (int i = 0; i < 4; i++) wbeat[i] = 32'hE000_0000 + i;
    write_burst(32'hFF8, 8'd3, 3'd2, 2'b01, 2'd0, 4'hF);
    checks++; if (b_resp !== 2'b11) begin errors++; $display("FAIL oor_bresp got %b exp 11", b_resp); end
    read_burst(32'hFF8, 8'd1, 3'd2, 2'b01, 2'd0);
    checks++; if (rd_data[0] !== 32'hE000_0000 || rd_data[1] !== 32'hE000_0001) begin
      errors++; $display("FAIL oor_inrange_write got %h %h exp e0000000 e0000001", rd_data[0], rd_data[1]);
    end
  endtask

  task automatic test_stall();
    int n = 0;
    int got = 0;
    logic stalled = 1'b0;
    logic [31:0] held = '0;
    for (int i = 0; i < 8; i++) wbeat[i] = 32'h1000_0100 + i;
    write_burst(32'h100, 8'd7, 3'd2, 2'b01, 2'd0, 4'hF);
    do_ar(32'h100, 8'd7, 3'd2, 2'b01, 2'd0);
    rready = 1'b0;
    while (got < 8 && n < 100) begin
      rready = ~rready;
      if (rvalid === 1'b1) begin
        if (stalled) begin
          checks++;
          if (rdata !== held) begin errors++; $display("FAIL stall_hold got %h exp %h", rdata, held); end
        end
        if (rready) begin
          rd_data[got] = rdata; rd_last[got] = rlast; got++; stalled = 1'b0;
        end else begin
          stalled = 1'b1; held = rdata;
        end
      end
      step(); n++;
    end
    rready = 1'b0;
    checks++; if (got != 8) begin errors++; $display("FAIL stall_count got %0d exp 8", got); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_data[i] !== 32'h1000_0100 + i || rd_last[i] !== (i == 7)) begin
        errors++; $display("FAIL stall_beat%0d got %h/%b exp %h/%b", i, rd_data[i], rd_last[i], 32'h1000_0100 + i, i == 7);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_d [4];
    logic [1:0]  exp_b;
    for (int i = 0; i < 4; i++) wbeat[i] = 32'h5000_0000 + i;
    write_burst(32'h30, 8'd3, 3'd2, 2'b01, 2'd0, 4'hF);
    for (int i = 0; i < 4; i++) wbeat[i] = 32'h7000_0000 + i;
    write_burst(32'h38, 8'd3, 3'd2, 2'b10, 2'd0, 4'hF);
`ifdef AXI_MEM_RESPONDER_WRAP_EN
    exp_b = 2'b00;
    exp_d[0] = 32'h7000_0002; exp_d[1] = 32'h7000_0003; exp_d[2] = 32'h7000_0000; exp_d[3] = 32'h7000_0001;
`else
    exp_b = 2'b10;
    for (int i = 0; i < 4; i++) exp_d[i] = 32'h5000_0000 + i;
`endif
    checks++; if (b_resp !== exp_b) begin errors++; $display("FAIL wrap_bresp got %b exp %b", b_resp, exp_b); end
    read_burst(32'h30, 8'd3, 3'd2, 2'b01, 2'd0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== exp_d[i]) begin errors++; $display("FAIL wrap_mem%0d got %h exp %h", i, rd_data[i], exp_d[i]); end
    end
    read_burst(32'h38, 8'd3, 3'd2, 2'b10, 2'd0);
    for (int i = 0; i < 4; i++) begin
`ifdef AXI_MEM_RESPONDER_WRAP_EN
      checks++;
      if (rd_data[i] !== 32'h7000_0000 + i || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3)) begin
        errors++; $display("FAIL wrap_rbeat%0d got %h/%b/%b exp %h/00", i, rd_data[i], rd_resp[i], rd_last[i], 32'h7000_0000 + i);
      end
`else
      checks++;
      if (rd_data[i] !== 32'h0 || rd_resp[i] !== 2'b10 || rd_last[i] !== (i == 3)) begin
        errors++; $display("FAIL wrap_rbeat%0d got %h/%b/%b exp 0/10", i, rd_data[i], rd_resp[i], rd_last[i]);
      end
`endif
    end
  endtask

  task automatic test_size_err();
    wbeat[0] = 32'h0000_1234;
    write_burst(32'h40, 8'd0, 3'd2, 2'b01, 2'd0, 4'hF);
    wbeat[0] = 32'h5555_5555;
    write_burst(32'h40, 8'd0, 3'd3, 2'b01, 2'd0, 4'hF);
    checks++; if (b_resp !== 2'b10) begin errors++; $display("FAIL size_bresp got %b exp 10", b_resp); end
    read_burst(32'h40, 8'd0, 3'd3, 2'b01, 2'd0);
    checks++; if (rd_resp[0] !== 2'b10 || rd_data[0] !== 32'h0) begin
      errors++; $display("FAIL size_rbeat got %h/%b exp 0/10", rd_data[0], rd_resp[0]);
    end
    read_burst(32'h40, 8'd0, 3'd2, 2'b01, 2'd0);
    checks++; if (rd_data[0] !== 32'h0000_1234) begin errors++; $display("FAIL size_dropped got %h exp 1234", rd_data[0]); end
  endtask

  task automatic test_fixed();
    wbeat[0] = 32'h2000_0000; wbeat[1] = 32'h2000_0001;
    write_burst(32'h200, 8'd1, 3'd2, 2'b01, 2'd0, 4'hF);
    wbeat[0] = 32'hF000_0000; wbeat[1] = 32'hF000_0001;
    write_burst(32'h200, 8'd1, 3'd2, 2'b00, 2'd0, 4'hF);
    read_burst(32'h200, 8'd1, 3'd2, 2'b01, 2'd0);
    checks++; if (rd_data[0] !== 32'hF000_0001 || rd_data[1] !== 32'h2000_0001) begin
      errors++; $display("FAIL fixed_write got %h %h exp f0000001 20000001", rd_data[0], rd_data[1]);
    end
    read_burst(32'h200, 8'd1, 3'd2, 2'b00, 2'd0);
    checks++; if (rd_data[0] !== 32'hF000_0001 || rd_data[1] !== 32'hF000_0001) begin
      errors++; $display("FAIL fixed_read got %h %h exp f0000001 f0000001", rd_data[0], rd_data[1]);
    end
  endtask

  task automatic test_reset_mid();
    logic seen_b = 1'b0;
    do_aw(32'h300, 8'd7, 3'd2, 2'b01, 2'd3);
    for (int i = 0; i < 2; i++) begin
      int n = 0;
      wdata = 32'h3000 + i; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      while (wready !== 1'b1 && n < 50) begin step(); n++; end
      step();
    end
    wdata = 32'h3002; wvalid = 1'b1; areset = 1'b1;
    step();
    checks++; if (awready !== 1'b0 || bvalid !== 1'b0 || wready !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got aw%b b%b w%b exp 000", awready, bvalid, wready);
    end
    areset = 1'b0; wvalid = 1'b0;
    step();
    checks++; if (awready !== 1'b1 || arready !== 1'b1) begin
      errors++; $display("FAIL midrst_ready got aw%b ar%b exp 11", awready, arready);
    end
    bready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bvalid === 1'b1) seen_b = 1'b1;
      step();
    end
    bready = 1'b0;
    checks++; if (seen_b !== 1'b0) begin errors++; $display("FAIL midrst_no_b got %b exp 0", seen_b); end
    read_burst(32'h300, 8'd1, 3'd2, 2'b01, 2'd0);
    checks++; if (rd_data[0] !== 32'h3000 || rd_data[1] !== 32'h3001) begin
      errors++; $display("FAIL midrst_mem_kept got %h %h exp 3000 3001", rd_data[0], rd_data[1]);
    end
  endtask

  initial begin
    areset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    test_reset();
    test_incr();
    test_strb();
    test_oor();
    test_stall();
    test_wrap();
    test_size_err();
    test_fixed();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 SHALL have parameter LOCAL_DATA_WIDTH, default 32: AXI data width in bits; 32 or 64 only.
REQ-002 SHALL have parameter LOCAL_ADDR_WIDTH, default 32: AXI address width in bits.
REQ-003 SHALL have parameter LOCAL_ID_WIDTH, default 2: AXI ID width in bits.
REQ-004 SHALL have parameter MEM_DEPTH, default 1024: number of words of width LOCAL_DATA_WIDTH; power of two.
REQ-005 SHALL have port s_axi_aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port s_axi_areset, input, 1 bit: reset; synchronous; active-high.
REQ-007 SHALL have the AW channel, all as inputs except s_axi_awready: s_axi_awid/awaddr/awlen(8)/awsize(3)/awburst(2)/awlock/awcache(4)/awprot(3)/awqos(4)/awregion(4)/awvalid; s_axi_awready is an output.
REQ-008 SHALL have the W channel: s_axi_wdata (input, LOCAL_DATA_WIDTH), s_axi_wstrb (input, LOCAL_DATA_WIDTH/8), s_axi_wlast (input), s_axi_wvalid (input), s_axi_wready (output).
REQ-009 SHALL have the B channel: s_axi_bid (output, ID), s_axi_bresp (output, 2), s_axi_bvalid (output), s_axi_bready (input).
REQ-010 SHALL have the AR channel, mirroring AW with the ar prefix; s_axi_arready is an output.
REQ-011 SHALL have the R channel: s_axi_rid (output, ID), s_axi_rdata (output), s_axi_rresp (output, 2), s_axi_rlast (output), s_axi_rvalid (output), s_axi_rready (input).

Function
REQ-012 Module SHALL be an AXI4 subordinate that terminates transactions in an internal word array; the write path and the read path SHALL run independently and concurrently.
REQ-013 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP; awready=1 only in W_IDLE; AW handshake SHALL latch id/addr/len/size/burst and go to W_DATA.
REQ-014 In W_DATA, wready SHALL be 1 and each W handshake SHALL write the bytes enabled by wstrb at the current word index, then advance the address; the beat with wlast=1 or beat len+1 SHALL move the FSM to W_RESP.
REQ-015 In W_RESP, bvalid=1 with the latched bid; the B handshake SHALL return the FSM to W_IDLE; bvalid SHALL stay stable until bready.
REQ-016 Read FSM SHALL have states R_IDLE and R_DATA; arready=1 only in R_IDLE; the AR handshake SHALL latch fields; the first rvalid SHALL rise exactly 1 cycle after the AR handshake (registered read).
REQ-017 Each R handshake SHALL present the next beat on the following cycle with no bubbles while rready=1; rlast=1 on beat len; the R handshake on the last beat SHALL return the FSM to R_IDLE.
REQ-018 rdata/rresp/rlast/rid SHALL remain stable while rvalid=1 and rready=0.
REQ-019 Address update SHALL be: FIXED keeps the address; INCR adds 2^size; word index = addr[log2(bytes)+: log2(MEM_DEPTH)].
REQ-020 A size greater than log2(LOCAL_DATA_WIDTH/8) SHALL yield SLVERR (2'b10) for that burst; its writes SHALL be dropped and its reads SHALL return zero data.
REQ-021 A beat whose byte address is >= MEM_DEPTH*bytes SHALL be out of range: the write is dropped and bresp=DECERR (2'b11) if any beat was out of range; a read beat gets rresp=DECERR and zero data, per beat.
REQ-022 A write and a read to the same word in the same cycle SHALL return the old data for the read.
REQ-023 lock, cache, prot, qos and region SHALL be ignored; exclusive access SHALL never return EXOKAY.

Reset
REQ-024 While s_axi_areset=1 at a clock edge, both FSMs SHALL go to IDLE and all outputs SHALL be 0, except awready=arready=1 from the first cycle after reset deasserts.
REQ-025 Reset mid-burst SHALL abandon the burst with no B or R response; array contents SHALL not be reset.

Configuration
REQ-026 With macro AXI_MEM_RESPONDER_WRAP_EN defined, WRAP bursts SHALL be supported: wrap boundary = (len+1)*2^size, the address wraps to the aligned boundary start, and len is restricted to 1, 3, 7 or 15.
REQ-027 Without the macro, or with an illegal WRAP len, a WRAP burst SHALL complete all handshakes with SLVERR, drop its writes and return zero read data.

Structure
REQ-028 The shared package SHALL hold the AXI burst encodings (FIXED/INCR/WRAP), the response encodings (OKAY/EXOKAY/SLVERR/DECERR) and the FSM state enums.
REQ-029 The next-address calculation SHALL be one sub-module, axi_burst_addr_gen, instantiated once on the write path and once on the read path.

Verification
REQ-030 INCR AW addr=0x10, len=3, size=2 with data A0..A3 and wstrb=F, then AR of the same: bresp=0, R returns A0..A3 with rlast on beat 3, and the first rvalid comes 1 cycle after AR.
REQ-031 Write 0xFFFFFFFF to 0x0, then write 0x000000AB with wstrb=0x1, then read 0x0: the read returns 0xFFFFFFAB.
REQ-032 INCR read addr=(MEM_DEPTH*4-8), len=3: beats 0-1 are OKAY, beats 2-3 are DECERR with zero data; a write of the same shape gets bresp=DECERR.
REQ-033 Read len=7 with rready toggled 1/0 each cycle: 8 beats arrive in order and the data is held stable during stalls.
REQ-034 WRAP len=3 size=2 at 0x38: with the macro, the addresses are 0x38, 0x3C, 0x30, 0x34 and OKAY; without it, all 4 beats and the B response are SLVERR.
REQ-035 Assert reset during beat 2 of a len=7 write: no bvalid follows, and awready=1 on the cycle after reset deasserts.
